neander_mem_responder: RTL and testbench

Memory-side responder for the Neander CPU's load/store traffic: a 256×8 byte-addressed RAM behind a request/acknowledge handshake with programmable wait states. It also provides a write-only loader port for program and data images; that port wins arbitration over the CPU. The block sits between the CPU's address/data registers and the RAM array, and lets the core run against slow memory models instead of a zero-latency array.

---
 rtl/neander_pkg.sv | 24 ++
 rtl/neander_mem_responder_if.sv | 27 ++
 rtl/neander_ram.sv | 24 ++
 rtl/neander_mem_responder.sv | 114 +++++++++++
 tb/tb_neander_mem_responder.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/neander_pkg.sv
// Shared types and constants for the Neander memory responder and program-building benches.
package neander_pkg;

  localparam int unsigned AddrWDef = 8;
  localparam int unsigned DataWDef = 8;
  localparam int unsigned WaitCntW = 4;

  typedef enum logic [1:0] {StIdle, StWait, StAck} state_e;
  typedef enum logic {OwnCpu, OwnLoader} owner_e;

  // Neander opcodes live in the upper nibble of the instruction byte
  localparam logic [7:0] OpNop = 8'h00;
  localparam logic [7:0] OpSta = 8'h10;
  localparam logic [7:0] OpLda = 8'h20;
  localparam logic [7:0] OpAdd = 8'h30;
  localparam logic [7:0] OpOr  = 8'h40;
  localparam logic [7:0] OpAnd = 8'h50;
  localparam logic [7:0] OpNot = 8'h60;
  localparam logic [7:0] OpJmp = 8'h80;
  localparam logic [7:0] OpJn  = 8'h90;
  localparam logic [7:0] OpJz  = 8'hA0;
  localparam logic [7:0] OpHlt = 8'hF0;

endpackage

// File: rtl/neander_mem_responder_if.sv
// CPU and loader request/acknowledge bus of the Neander memory responder.
interface neander_mem_responder_if #(
  parameter int unsigned ADDR_W = neander_pkg::AddrWDef,
  parameter int unsigned DATA_W = neander_pkg::DataWDef
);
  logic              i_req;
  logic              i_we;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_wdata;
  logic              o_ack;
  logic [DATA_W-1:0] o_rdata;
  logic              i_ld_req;
  logic [ADDR_W-1:0] i_ld_addr;
  logic [DATA_W-1:0] i_ld_data;
  logic              o_ld_ack;
  logic              o_busy;

  modport master (
    output i_req, i_we, i_addr, i_wdata, i_ld_req, i_ld_addr, i_ld_data,
    input  o_ack, o_rdata, o_ld_ack, o_busy
  );

  modport slave (
    input  i_req, i_we, i_addr, i_wdata, i_ld_req, i_ld_addr, i_ld_data,
    output o_ack, o_rdata, o_ld_ack, o_busy
  );
endinterface

// File: rtl/neander_ram.sv
// Plain synchronous RAM: one write port, one registered read port, no reset.
module neander_ram #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);
  localparam int unsigned Depth = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [Depth];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/neander_mem_responder.sv
// Neander memory responder: loader-first arbiter, wait-state FSM and registered handshake.
module neander_mem_responder
  import neander_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 1,
  parameter int unsigned ADDR_W      = AddrWDef,
  parameter int unsigned DATA_W      = DataWDef
) (
  input logic                   i_clk,
  input logic                   i_rst_n,
  neander_mem_responder_if.slave bus
);
  localparam logic [WaitCntW-1:0] WaitLoad = WaitCntW'(WAIT_STATES);

  state_e              state_q;
  owner_e              owner_q;
  logic [WaitCntW-1:0] cnt_q;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                ack_q;
  logic                ld_ack_q;
  logic                busy_q;

  logic                ram_we;
  logic [ADDR_W-1:0]   ram_raddr;
  logic [DATA_W-1:0]   ram_rdata;
  logic                access_now;

  assign access_now = (state_q == StWait) && (cnt_q == '0);
  assign ram_we     = access_now && we_q;

  // Point the read port at the incoming address while idle so the registered
  // read data is already valid on the access edge, even with zero wait states.
  always_comb begin
    ram_raddr = addr_q;
    if (state_q == StIdle) ram_raddr = bus.i_ld_req ? bus.i_ld_addr : bus.i_addr;
  end

  neander_ram #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_ram (
    .clk_i  (i_clk),
    .we_i   (ram_we),
    .waddr_i(addr_q),
    .wdata_i(wdata_q),
    .raddr_i(ram_raddr),
    .rdata_o(ram_rdata)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= StIdle;
      owner_q  <= OwnCpu;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      ack_q    <= 1'b0;
      ld_ack_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      ack_q    <= 1'b0;
      ld_ack_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.i_ld_req) begin
            addr_q  <= bus.i_ld_addr;
            wdata_q <= bus.i_ld_data;
            we_q    <= 1'b1;
            owner_q <= OwnLoader;
            cnt_q   <= WaitLoad;
            busy_q  <= 1'b1;
            state_q <= StWait;
          end else if (bus.i_req) begin
            addr_q  <= bus.i_addr;
            wdata_q <= bus.i_wdata;
            we_q    <= bus.i_we;
            owner_q <= OwnCpu;
            cnt_q   <= WaitLoad;
            busy_q  <= 1'b1;
            state_q <= StWait;
          end
        end
        StWait: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            if (!we_q) rdata_q <= ram_rdata;
            if (owner_q == OwnCpu) ack_q <= 1'b1;
            else                   ld_ack_q <= 1'b1;
            state_q <= StAck;
          end
        end
        StAck: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.o_ack    = ack_q;
  assign bus.o_ld_ack = ld_ack_q;
  assign bus.o_busy   = busy_q;
  assign bus.o_rdata  = rdata_q;
endmodule

// File: tb/tb_neander_mem_responder.sv
// Bench for neander_mem_responder: three instances (1, 0 and 3 wait states) with an ack scoreboard.
module tb_neander_mem_responder;

  logic       clk;
  logic       rst_n   [3];
  logic       req     [3];
  logic       we      [3];
  logic [7:0] addr    [3];
  logic [7:0] wdata   [3];
  logic       ld_req  [3];
  logic [7:0] ld_addr [3];
  logic [7:0] ld_data [3];
  logic       ack     [3];
  logic       ld_ack  [3];
  logic       busy    [3];
  logic [7:0] rdata   [3];

  typedef struct packed {
    logic [1:0] k;
    logic       ld;
    logic       chk;
    logic [7:0] data;
  } sb_t;

  sb_t        sb_q[$];
  logic [7:0] model [3][256];
  int         n_cmp = 0;
  int         n_bad = 0;

  neander_mem_responder_if bus [3] ();

  for (genvar g = 0; g < 3; g++) begin : g_dut
    assign bus[g].i_req     = req[g];
    assign bus[g].i_we      = we[g];
    assign bus[g].i_addr    = addr[g];
    assign bus[g].i_wdata   = wdata[g];
    assign bus[g].i_ld_req  = ld_req[g];
    assign bus[g].i_ld_addr = ld_addr[g];
    assign bus[g].i_ld_data = ld_data[g];
    assign ack[g]           = bus[g].o_ack;
    assign ld_ack[g]        = bus[g].o_ld_ack;
    assign busy[g]          = bus[g].o_busy;
    assign rdata[g]         = bus[g].o_rdata;

    neander_mem_responder #(
      .WAIT_STATES(g == 0 ? 1 : (g == 1 ? 0 : 3)),
      .ADDR_W     (8),
      .DATA_W     (8)
    ) u_dut (
      .i_clk  (clk),
      .i_rst_n(rst_n[g]),
      .bus    (bus[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // n = cycles until the ack, 0 if the bound expired
  task automatic wait_done(input int k, input bit ld, output int n);
    n = 0;
    for (int i = 1; i <= 64; i++) begin
      tick();
      if ((ld ? ld_ack[k] : ack[k]) === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic sb_push(input int k, input bit ld, input bit chk, input logic [7:0] d);
    sb_t e;
    e.k    = 2'(k);
    e.ld   = ld;
    e.chk  = chk;
    e.data = d;
    sb_q.push_back(e);
  endtask

  // Called in cycle 0 of the access; returns in the IDLE cycle after it.
  task automatic access(input int k, input bit ld, input bit w, input logic [7:0] a,
                        input logic [7:0] d, input int exp_lat, input string tag);
    int n;
    sb_push(k, ld, !ld && !w, model[k][a]);
    if (ld || w) model[k][a] = d;
    if (ld) begin
      ld_req[k] = 1'b1; ld_addr[k] = a; ld_data[k] = d;
    end else begin
      req[k] = 1'b1; we[k] = w; addr[k] = a; wdata[k] = d;
    end
    wait_done(k, ld, n);
    check_eq({tag, "_lat"}, n, exp_lat);
    ld_req[k] = 1'b0;
    req[k]    = 1'b0;
    tick();
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (ack[k] === 1'b1 || ld_ack[k] === 1'b1) begin
        if (sb_q.size() == 0) begin
          check_eq("sb_unexpected_ack", sb_q.size(), 1);
        end else begin
          sb_t e;
          e = sb_q.pop_front();
          check_eq("sb_inst", k, e.k);
          check_eq("sb_kind", ld_ack[k], e.ld);
          check_eq("sb_single_ack", ack[k] & ld_ack[k], 0);
          if (e.chk) check_eq("sb_rdata", rdata[k], e.data);
        end
      end
    end
  end

  initial begin
    int n;
    int acks;
    for (int k = 0; k < 3; k++) begin
      rst_n[k] = 1'b0; req[k] = 1'b0; we[k] = 1'b0; addr[k] = '0; wdata[k] = '0;
      ld_req[k] = 1'b0; ld_addr[k] = '0; ld_data[k] = '0;
    end
    repeat (2) tick();
    for (int k = 0; k < 3; k++) begin
      check_eq("rst_ack", ack[k], 0);
      check_eq("rst_ld_ack", ld_ack[k], 0);
      check_eq("rst_busy", busy[k], 0);
      check_eq("rst_rdata", rdata[k], 0);
      rst_n[k] = 1'b1;
    end
    tick();

    // One wait state: loader write then CPU read of the same byte
    access(0, 1, 1, 8'h80, 8'h2A, 3, "ws1_ld");
    access(0, 0, 0, 8'h80, 8'h00, 3, "ws1_rd");
    repeat (3) tick();
    check_eq("ws1_rdata_hold", rdata[0], 8'h2A);
    for (int i = 0; i < 4; i++) begin
      access(0, 0, 1, 8'h40 + 8'(i), 8'($urandom_range(0, 255)), 3, "ws1_cpu_wr");
    end
    for (int i = 3; i >= 0; i--) access(0, 0, 0, 8'h40 + 8'(i), 8'h00, 3, "ws1_cpu_rd");

    // Both requests in the same IDLE cycle: loader first, CPU read sees its data
    sb_push(0, 1, 1'b0, 8'h00);
    model[0][0] = 8'h99;
    sb_push(0, 0, 1'b1, 8'h99);
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 8'h00;
    ld_req[0] = 1'b1; ld_addr[0] = 8'h00; ld_data[0] = 8'h99;
    wait_done(0, 1, n);
    check_eq("arb_ld_lat", n, 3);
    ld_req[0] = 1'b0;
    wait_done(0, 0, n);
    check_eq("arb_cpu_after_ld", n, 4);
    req[0] = 1'b0;
    tick();

    // Zero wait states, request held: write then read with one IDLE cycle between
    sb_push(1, 0, 1'b0, 8'h00);
    model[1][8'h10] = 8'h55;
    sb_push(1, 0, 1'b1, 8'h55);
    req[1] = 1'b1; we[1] = 1'b1; addr[1] = 8'h10; wdata[1] = 8'h55;
    wait_done(1, 0, n);
    check_eq("b2b_wr_lat", n, 2);
    we[1] = 1'b0;
    tick();
    check_eq("b2b_idle_busy", busy[1], 0);
    tick();
    check_eq("b2b_wait_busy", busy[1], 1);
    wait_done(1, 0, n);
    check_eq("b2b_rd_gap", n, 1);
    req[1] = 1'b0;
    tick();

    // Reset during WAIT of a CPU write: no ack, no write
    access(2, 1, 1, 8'h20, 8'h11, 5, "ws3_ld");
    req[2] = 1'b1; we[2] = 1'b1; addr[2] = 8'h20; wdata[2] = 8'hFF;
    tick();
    tick();
    check_eq("ws3_busy_in_wait", busy[2], 1);
    rst_n[2] = 1'b0;
    req[2]   = 1'b0;
    #1;
    check_eq("rst_mid_busy", busy[2], 0);
    tick();
    rst_n[2] = 1'b1;
    acks = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (ack[2] === 1'b1) acks++;
    end
    check_eq("rst_mid_no_ack", acks, 0);
    access(2, 0, 0, 8'h20, 8'h00, 5, "ws3_rd_after_rst");

    // Preloaded memory survives reset; loader writes never touch o_rdata
    for (int i = 0; i < 4; i++) access(1, 1, 1, 8'h30 + 8'(i), 8'hA0 + 8'(i), 2, "pre_ld");
    check_eq("ld_keeps_rdata", rdata[1], 8'h55);
    rst_n[1] = 1'b0;
    tick();
    rst_n[1] = 1'b1;
    tick();
    check_eq("rst_clears_rdata", rdata[1], 0);
    access(1, 1, 1, 8'h34, 8'hC3, 2, "post_rst_ld");
    check_eq("post_rst_ld_rdata", rdata[1], 0);
    access(1, 0, 0, 8'h31, 8'h00, 2, "persist_rd31");
    access(1, 0, 0, 8'h10, 8'h00, 2, "persist_rd10");
    access(1, 0, 0, 8'h33, 8'h00, 2, "persist_rd33");
    access(1, 1, 1, 8'h31, 8'h5A, 2, "ovr_ld");
    check_eq("ovr_ld_rdata", rdata[1], 8'hA3);
    access(1, 0, 0, 8'h31, 8'h00, 2, "ovr_rd");
    access(1, 0, 0, 8'h34, 8'h00, 2, "post_rst_rd");

    repeat (5) tick();
    check_eq("sb_drain", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
